// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - single-issue instruction fetch unit; YSYX_22050612_IFU_ALIGN_CHECK_EN enables the dnpc alignment fault
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        dnpc_valid,
    input  logic [63:0] dnpc,
    output logic        fetch_fault,
    output logic [63:0] fault_pc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_EXEC  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [31:0] inst_q;
    logic [63:0] fault_pc_q;

    // A response is only consumed while the fetch is actually outstanding.
    logic resp_fire;
    assign resp_fire = ((state == S_FETCH) && mem_gnt && mem_rvalid) ||
                       ((state == S_WAIT) && mem_rvalid);

    logic dnpc_fire;
    assign dnpc_fire = (state == S_EXEC) && dnpc_valid;

    logic dnpc_misaligned;
`ifdef YSYX_22050612_IFU_ALIGN_CHECK_EN
    assign dnpc_misaligned = (dnpc[1:0] != 2'b00);
`else
    assign dnpc_misaligned = 1'b0;
`endif

    // State register; reset drops any response in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode of the fetch handshake sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_gnt && mem_rvalid) begin
                    state_nxt = mem_err ? S_FAULT : S_VALID;
                end else if (mem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = mem_err ? S_FAULT : S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ready) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dnpc_valid) begin
                    state_nxt = dnpc_misaligned ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        mem_req     = 1'b0;
        inst_valid  = 1'b0;
        fetch_fault = 1'b0;
        case (state)
            S_FETCH: mem_req     = 1'b1;
            S_VALID: inst_valid  = 1'b1;
            S_FAULT: fetch_fault = 1'b1;
            default: ;
        endcase
    end

    // PC, instruction and fault-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst_q     <= 32'd0;
            fault_pc_q <= 64'd0;
        end else begin
            if (resp_fire) begin
                if (mem_err) begin
                    fault_pc_q <= pc;
                end else begin
                    inst_q <= mem_rdata;
                end
            end
            if (dnpc_fire) begin
                if (dnpc_misaligned) begin
                    fault_pc_q <= dnpc;
                end else begin
                    // Low bits are forced to zero so an unchecked target still fetches a word.
                    pc <= dnpc & ~64'd3;
                end
            end
        end
    end

    assign mem_addr = pc;
    assign inst_pc  = pc;
    assign inst     = inst_q;
    assign fault_pc = fault_pc_q;

endmodule
